// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable synchronized lock,
// then releases the system reset; loss of lock or lock timeout re-arms the PLL.
module pll_lock_supervisor #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             locked,
   input  logic             clr_status,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] retry_cnt,
   output logic             lock_lost
);

   localparam int unsigned MaxA   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MaxCnt = (MaxA > STABLE_CYCLES) ? MaxA : STABLE_CYCLES;
   localparam int unsigned CB     = $clog2(MaxCnt + 1);

   typedef enum logic [1:0] {
      StRstPll   = 2'b00,
      StWaitLock = 2'b01,
      StStable   = 2'b10,
      StRun      = 2'b11
   } state_t;

   state_t                 state_q;
   logic [CB-1:0]          cnt_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   logic [CNT_W-1:0]       retry_base;
   logic [CNT_W-1:0]       retry_inc;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
      end
   end

   assign locked_s = sync_q[SYNC_STAGES-1];
   assign state_o  = state_q;

   // A clear in the same cycle as a retry event clears first, then the event applies.
   always_comb begin
      retry_base = clr_status ? '0 : retry_cnt;
      retry_inc  = (&retry_base) ? retry_base : retry_base + CNT_W'(1);
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StRstPll;
         cnt_q     <= '0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         retry_cnt <= '0;
         lock_lost <= 1'b0;
      end else begin
         if (clr_status) begin
            retry_cnt <= '0;
            lock_lost <= 1'b0;
         end
         case (state_q)
            StRstPll: begin
               if (cnt_q == CB'(RST_CYCLES - 1)) begin
                  state_q <= StWaitLock;
                  pll_rst <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CB'(1);
               end
            end
            StWaitLock: begin
               if (locked_s) begin
                  state_q <= StStable;
                  cnt_q   <= '0;
               end else if (cnt_q == CB'(LOCK_TIMEOUT - 1)) begin
                  state_q   <= StRstPll;
                  pll_rst   <= 1'b1;
                  cnt_q     <= '0;
                  retry_cnt <= retry_inc;
               end else begin
                  cnt_q <= cnt_q + CB'(1);
               end
            end
            StStable: begin
               // The entry edge already saw one locked sample, hence the -2.
               if (!locked_s) begin
                  state_q <= StWaitLock;
                  cnt_q   <= '0;
               end else if (cnt_q == CB'(STABLE_CYCLES - 2)) begin
                  state_q   <= StRun;
                  sys_rst_n <= 1'b1;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CB'(1);
               end
            end
            StRun: begin
               if (!locked_s) begin
                  state_q   <= StRstPll;
                  pll_rst   <= 1'b1;
                  sys_rst_n <= 1'b0;
                  cnt_q     <= '0;
                  lock_lost <= 1'b1;
                  retry_cnt <= retry_inc;
               end
            end
            default: begin
               state_q <= StRstPll;
               pll_rst <= 1'b1;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

   logic       refclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       locked = 1'b0;
   logic       clr_status = 1'b0;
   logic       pll_rst;
   logic       sys_rst_n;
   logic [1:0] state_o;
   logic [2:0] retry_cnt;
   logic       lock_lost;

   logic [7:0] obs;
   logic [7:0] exp_v;
   int         n_run = 0;
   int         n_fail = 0;

   pll_lock_supervisor #(
      .SYNC_STAGES  (2),
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .CNT_W        (3)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .locked    (locked),
      .clr_status(clr_status),
      .pll_rst   (pll_rst),
      .sys_rst_n (sys_rst_n),
      .state_o   (state_o),
      .retry_cnt (retry_cnt),
      .lock_lost (lock_lost)
   );

   always #5 refclk = ~refclk;

   assign obs = {state_o, pll_rst, sys_rst_n, retry_cnt, lock_lost};

   // Packs {state, pll_rst, sys_rst_n, retry_cnt, lock_lost}.
   function automatic logic [7:0] ex(input logic [1:0] st, input logic pr, input logic sr,
                                     input logic [2:0] rc, input logic ll);
      return {st, pr, sr, rc, ll};
   endfunction

   task automatic tick();
      @(posedge refclk);
      @(negedge refclk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      locked = 1'b0;
      clr_status = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic bring_up();
      apply_reset();
      repeat (10) tick();
      locked = 1'b1;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      @(negedge refclk);
      exp_v = ex(2'b00, 1'b1, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL reset_vals: got %b expected %b", obs, exp_v);
      end
   endtask

   task automatic test_power_up();
      apply_reset();
      repeat (3) tick();
      exp_v = ex(2'b00, 1'b1, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL pu_rst_hi: got %b expected %b", obs, exp_v);
      end
      tick();
      exp_v = ex(2'b01, 1'b0, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL pu_rst_lo: got %b expected %b", obs, exp_v);
      end
      repeat (6) tick();
      locked = 1'b1;
      repeat (9) tick();
      exp_v = ex(2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL pu_pre_release: got %b expected %b", obs, exp_v);
      end
      tick();
      exp_v = ex(2'b11, 1'b0, 1'b1, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL pu_release: got %b expected %b", obs, exp_v);
      end
   endtask

   task automatic test_never_lock();
      apply_reset();
      repeat (4) tick();
      for (int k = 1; k <= 9; k++) begin
         repeat (19) tick();
         exp_v = ex(2'b01, 1'b0, 1'b0, 3'((k - 1 > 7) ? 7 : k - 1), 1'b0);
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL nl_wait_end k=%0d: got %b expected %b", k, obs, exp_v);
         end
         tick();
         exp_v = ex(2'b00, 1'b1, 1'b0, 3'((k > 7) ? 7 : k), 1'b0);
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL nl_timeout k=%0d: got %b expected %b", k, obs, exp_v);
         end
         repeat (4) tick();
         exp_v = ex(2'b01, 1'b0, 1'b0, 3'((k > 7) ? 7 : k), 1'b0);
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL nl_pulse_len k=%0d: got %b expected %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      repeat (10) tick();
      locked = 1'b1;
      repeat (5) tick();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      tick();
      exp_v = ex(2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL gl_still_stable: got %b expected %b", obs, exp_v);
      end
      tick();
      exp_v = ex(2'b01, 1'b0, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL gl_back_wait: got %b expected %b", obs, exp_v);
      end
      repeat (7) tick();
      exp_v = ex(2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL gl_pre_release: got %b expected %b", obs, exp_v);
      end
      tick();
      exp_v = ex(2'b11, 1'b0, 1'b1, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL gl_release: got %b expected %b", obs, exp_v);
      end
   endtask

   task automatic test_loss_run();
      bring_up();
      locked = 1'b0;
      repeat (2) tick();
      exp_v = ex(2'b11, 1'b0, 1'b1, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL loss_edge2: got %b expected %b", obs, exp_v);
      end
      tick();
      exp_v = ex(2'b00, 1'b1, 1'b0, 3'd1, 1'b1);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL loss_edge3: got %b expected %b", obs, exp_v);
      end
   endtask

   task automatic test_clr_collision();
      bring_up();
      locked = 1'b0;
      repeat (3) tick();
      locked = 1'b1;
      repeat (12) tick();
      exp_v = ex(2'b11, 1'b0, 1'b1, 3'd1, 1'b1);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL clr_relock: got %b expected %b", obs, exp_v);
      end
      locked = 1'b0;
      repeat (2) tick();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      exp_v = ex(2'b00, 1'b1, 1'b0, 3'd1, 1'b1);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL clr_vs_event: got %b expected %b", obs, exp_v);
      end
      tick();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      exp_v = ex(2'b00, 1'b1, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL clr_lone: got %b expected %b", obs, exp_v);
      end
   endtask

   task automatic test_async_reset();
      bring_up();
      exp_v = ex(2'b11, 1'b0, 1'b1, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL ar_in_run: got %b expected %b", obs, exp_v);
      end
      #3 rst_n = 1'b0;
      #1;
      exp_v = ex(2'b00, 1'b1, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL ar_immediate: got %b expected %b", obs, exp_v);
      end
      @(negedge refclk);
      rst_n = 1'b1;
      repeat (3) tick();
      exp_v = ex(2'b00, 1'b1, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL ar_rst_pll: got %b expected %b", obs, exp_v);
      end
      tick();
      exp_v = ex(2'b01, 1'b0, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL ar_wait: got %b expected %b", obs, exp_v);
      end
      repeat (7) tick();
      exp_v = ex(2'b10, 1'b0, 1'b0, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL ar_stable: got %b expected %b", obs, exp_v);
      end
      tick();
      exp_v = ex(2'b11, 1'b0, 1'b1, 3'd0, 1'b0);
      n_run++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL ar_run: got %b expected %b", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_never_lock();
      test_glitch();
      test_loss_run();
      test_clr_collision();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
